// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads instruction RAM at the current PC and holds
// the result in an instruction register until the control unit acks it.
// Optional feature macro: FETCH_STALL_CNT_EN adds a saturating stall counter
// output (stall_cnt) that counts edges spent in WAIT or HOLD.
module instr_fetch #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fetch_req,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic              pc_inc,
`ifdef FETCH_STALL_CNT_EN
  output logic              busy,
  output logic [15:0]       stall_cnt
`else
  output logic              busy
`endif
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t              state_reg, state_next;
  logic                busy_reg;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic                mem_rd_en_reg, mem_rd_en_next;
  logic [DATA_W-1:0]   ir_reg, ir_next;
  logic                ir_valid_reg, ir_valid_next;
  logic                pc_inc_reg, pc_inc_next;

  // State register; busy is registered alongside so it tracks the state exactly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != S_IDLE);
    end
  end

  // Next-state logic; flush always returns to IDLE and beats both ack and request
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (fetch_req && !flush) state_next = S_WAIT;
      S_WAIT: begin
        if (flush)               state_next = S_IDLE;
        else if (cnt_reg == '0)  state_next = S_HOLD;
      end
      S_HOLD: if (flush || ir_ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the latency counter
  always_comb begin
    cnt_next       = cnt_reg;
    mem_addr_next  = mem_addr_reg;
    mem_rd_en_next = 1'b0;
    ir_next        = ir_reg;
    ir_valid_next  = ir_valid_reg;
    pc_inc_next    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (fetch_req && !flush) begin
          mem_addr_next  = pc_in;
          mem_rd_en_next = 1'b1;
          cnt_next       = CNT_W'(MEM_LATENCY);
        end
      end
      S_WAIT: begin
        if (flush) begin
          ir_valid_next = 1'b0;
        end else if (cnt_reg == '0) begin
          ir_next       = mem_rdata;
          ir_valid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          ir_valid_next = 1'b0;
        end else if (ir_ack) begin
          ir_valid_next = 1'b0;
          pc_inc_next   = 1'b1;
        end
      end
      default: ir_valid_next = 1'b0;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg       <= '0;
      mem_addr_reg  <= '0;
      mem_rd_en_reg <= 1'b0;
      ir_reg        <= '0;
      ir_valid_reg  <= 1'b0;
      pc_inc_reg    <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      mem_addr_reg  <= mem_addr_next;
      mem_rd_en_reg <= mem_rd_en_next;
      ir_reg        <= ir_next;
      ir_valid_reg  <= ir_valid_next;
      pc_inc_reg    <= pc_inc_next;
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_rd_en = mem_rd_en_reg;
  assign ir_out    = ir_reg;
  assign ir_valid  = ir_valid_reg;
  assign pc_inc    = pc_inc_reg;
  assign busy      = busy_reg;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  // Saturating count of edges spent in WAIT or HOLD; only reset clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (state_reg != S_IDLE && stall_cnt_reg != 16'hFFFF) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: table of fetch transactions plus hand-written
// sequences for reset, flush/request collision and (optionally) stall count.
module tb_instr_fetch;

  localparam int LAT = 1;

  logic        clk;
  logic        reset;
  logic [15:0] pc_in;
  logic        fetch_req;
  logic        flush;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ir_ack;
  logic        pc_inc;
  logic        busy;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  instr_fetch #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .fetch_req (fetch_req),
    .flush     (flush),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .ir_ack    (ir_ack),
    .pc_inc    (pc_inc),
`ifdef FETCH_STALL_CNT_EN
    .busy      (busy),
    .stall_cnt (stall_cnt)
`else
    .busy      (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] sb_q[$];
  logic [15:0] last_ir  = 16'h0000;
  int          exp_stall = 0;

  // mode: 0 = ack, 1 = flush in WAIT, 2 = flush in HOLD, 3 = flush+ack in HOLD
  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
    int          ack_wait;
    int          mode;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stall();
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt", {16'h0, stall_cnt}, exp_stall[31:0]);
`endif
  endtask

  task automatic add_stall(input int n);
    exp_stall = exp_stall + n;
    if (exp_stall > 65535) exp_stall = 65535;
  endtask

  task automatic run_fetch(input vec_t v);
    logic [15:0] exp_ir;
    pc_in     = v.pc;
    mem_rdata = v.data;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("rd_en_pulse", {31'h0, mem_rd_en}, 32'h1);
    chk("mem_addr", {16'h0, mem_addr}, {16'h0, v.pc});
    chk("busy_wait", {31'h0, busy}, 32'h1);
    if (v.mode == 1) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      add_stall(1);
      chk("flushw_valid", {31'h0, ir_valid}, 32'h0);
      chk("flushw_ir", {16'h0, ir_out}, {16'h0, last_ir});
      chk("flushw_busy", {31'h0, busy}, 32'h0);
      chk("flushw_rd_en", {31'h0, mem_rd_en}, 32'h0);
      tick();
      chk("flushw_inc", {31'h0, pc_inc}, 32'h0);
      chk("flushw_ir2", {16'h0, ir_out}, {16'h0, last_ir});
      check_stall();
      $display("vec pc=%h mode=%0d flushed in WAIT", v.pc, v.mode);
      return;
    end
    sb_q.push_back(v.data);
    for (int i = 0; i < LAT; i++) begin
      tick();
      chk("wait_valid", {31'h0, ir_valid}, 32'h0);
      chk("wait_rd_en", {31'h0, mem_rd_en}, 32'h0);
    end
    tick();
    add_stall(LAT + 1);
    chk("cap_valid", {31'h0, ir_valid}, 32'h1);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sb_underflow: got capture expected none at %0t", $time);
      exp_ir = 16'hxxxx;
    end else begin
      exp_ir = sb_q.pop_front();
      chk("ir_out", {16'h0, ir_out}, {16'h0, exp_ir});
    end
    last_ir   = exp_ir;
    mem_rdata = ~v.data;
    // Hold phase: requests must be ignored and IR must not move
    fetch_req = 1'b1;
    pc_in     = v.pc + 16'h0100;
    for (int i = 0; i < v.ack_wait; i++) begin
      tick();
      chk("hold_valid", {31'h0, ir_valid}, 32'h1);
      chk("hold_ir", {16'h0, ir_out}, {16'h0, exp_ir});
      chk("hold_inc", {31'h0, pc_inc}, 32'h0);
      chk("hold_rd_en", {31'h0, mem_rd_en}, 32'h0);
    end
    fetch_req = 1'b0;
    ir_ack    = (v.mode == 0 || v.mode == 3);
    flush     = (v.mode == 2 || v.mode == 3);
    tick();
    ir_ack = 1'b0;
    flush  = 1'b0;
    add_stall(v.ack_wait + 1);
    chk("end_valid", {31'h0, ir_valid}, 32'h0);
    chk("end_inc", {31'h0, pc_inc}, (v.mode == 0) ? 32'h1 : 32'h0);
    chk("end_busy", {31'h0, busy}, 32'h0);
    chk("end_ir", {16'h0, ir_out}, {16'h0, exp_ir});
    tick();
    chk("inc_one_cycle", {31'h0, pc_inc}, 32'h0);
    check_stall();
    $display("vec pc=%h data=%h ack_wait=%0d mode=%0d ir=%h", v.pc, v.data, v.ack_wait, v.mode, ir_out);
  endtask

  initial begin
    vecs[0] = '{16'h0010, 16'hA5C3, 0, 0};
    vecs[1] = '{16'h0020, 16'h1234, 5, 0};
    vecs[2] = '{16'h0004, 16'hBEEF, 2, 1};
    vecs[3] = '{16'hFFFF, 16'h5A5A, 1, 2};
    vecs[4] = '{16'h0030, 16'h0F0F, 0, 3};
    vecs[5] = '{16'h0040, 16'hC001, 2, 0};
    vecs[6] = '{16'h0050, 16'h7777, 0, 1};

    reset = 1'b0; pc_in = 16'h0; fetch_req = 1'b0; flush = 1'b0;
    mem_rdata = 16'h0; ir_ack = 1'b0;
    #12;
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    chk("rst_ir", {16'h0, ir_out}, 32'h0);
    chk("rst_valid", {31'h0, ir_valid}, 32'h0);
    chk("rst_inc", {31'h0, pc_inc}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b1;
    tick();
    check_stall();
    $display("reset state checked");

    for (int i = 0; i < 7; i++) run_fetch(vecs[i]);

    // Request and flush on the same IDLE edge: no read issued
    pc_in = 16'h0060; fetch_req = 1'b1; flush = 1'b1;
    tick();
    fetch_req = 1'b0; flush = 1'b0;
    chk("idle_flush_rd_en", {31'h0, mem_rd_en}, 32'h0);
    chk("idle_flush_busy", {31'h0, busy}, 32'h0);
    check_stall();
    $display("fetch_req+flush in IDLE: rd_en=%b busy=%b", mem_rd_en, busy);

`ifdef FETCH_STALL_CNT_EN
    // Preload the counter near its limit and confirm it saturates
    force dut.stall_cnt_reg = 16'hFFFE;
    #1;
    release dut.stall_cnt_reg;
    exp_stall = 65534;
    run_fetch(vecs[0]);
    chk("stall_sat", {16'h0, stall_cnt}, 32'h0000FFFF);
    $display("stall counter saturation: %h", stall_cnt);
`endif

    // Asynchronous reset asserted mid-WAIT
    pc_in = 16'h0004; mem_rdata = 16'h1111; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_addr", {16'h0, mem_addr}, 32'h0);
    chk("arst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    chk("arst_ir", {16'h0, ir_out}, 32'h0);
    chk("arst_valid", {31'h0, ir_valid}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    sb_q.delete();
    last_ir = 16'h0; exp_stall = 0;
    #5;
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("post_rst_valid", {31'h0, ir_valid}, 32'h0);
    check_stall();
    $display("async reset mid-WAIT checked");

    run_fetch(vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
